// File: rtl/fp_pipe_pkg.sv
// Shared types and helpers for the pipelined FP adder datapath.
// Holds the (generate, propagate) pair type, the add/sub op encoding
// and a constant-foldable ceil(log2) used to size prefix trees.
package fp_pipe_pkg;

  // One prefix-tree entry: group generate and group propagate.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // ceil(log2(v)) for v >= 1; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone (G,P) combine operator: folds a lower group into a higher one.
// Latency: combinational, zero cycles.
// Backpressure: none, pure logic.
// Ports: hi_i = more-significant group, lo_i = adjacent less-significant
//        group, res_o = combined group spanning both.
module prefix_cell
  import fp_pipe_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t res_o
);

  assign res_o.g = hi_i.g | (hi_i.p & lo_i.g);
  assign res_o.p = hi_i.p & lo_i.p;

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with carry/borrow-in, flags and tag.
// Latency: clog2(WIDTH)+2 cycles from acceptance to out_valid; 1 op/cycle.
// Backpressure: one global enable (~out_valid | out_ready) freezes every stage, bubbles included.
// Ports: clk/rst_n (async active-low); in_valid/in_ready + a, b, sub, cin,
//        tag_in on the input side; out_valid/out_ready + sum, cout (1 = no
//        borrow when subtracting), ovf (signed), zero, tag_out on the output.
module prefix_addsub_pipe
  import fp_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int WINDOW = 1 << LEVELS;

  logic en;
  logic out_valid_q;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Stage view: index 0 is S0, index k is the output of prefix level k.
  // Entry 0 of each gp vector is the carry-in; entry i+1 belongs to bit i.
  gp_t  [WIDTH:0]   stage_gp  [0:LEVELS];
  logic [WIDTH-1:0] stage_hs  [0:LEVELS];
  logic [TAG_W-1:0] stage_tag [0:LEVELS];
  logic [LEVELS:0]  stage_vld;

  // ---------------- S0: operand conditioning and bitwise g/p ----------------
  logic             is_sub;
  logic             c0;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s0_hs_d;
  gp_t  [WIDTH:0]   s0_gp_d;

  gp_t  [WIDTH:0]   s0_gp_q;
  logic [WIDTH-1:0] s0_hs_q;
  logic [TAG_W-1:0] s0_tag_q;
  logic             s0_vld_q;

  // Subtract is A + ~B + ~borrow, so both B and the carry-in get inverted.
  always_comb begin
    is_sub     = (sub == OP_SUB);
    b_eff      = b ^ {WIDTH{is_sub}};
    c0         = cin ^ is_sub;
    s0_hs_d    = a ^ b_eff;
    s0_gp_d    = '0;
    s0_gp_d[0] = '{g: c0, p: c0};
    for (int i = 0; i < WIDTH; i++) begin
      s0_gp_d[i+1].g = a[i] & b_eff[i];
      s0_gp_d[i+1].p = s0_hs_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q <= 1'b0;
      s0_gp_q  <= '0;
      s0_hs_q  <= '0;
      s0_tag_q <= '0;
    end else if (en) begin
      s0_vld_q <= in_valid;
      s0_gp_q  <= s0_gp_d;
      s0_hs_q  <= s0_hs_d;
      s0_tag_q <= tag_in;
    end
  end

  assign stage_gp[0]  = s0_gp_q;
  assign stage_hs[0]  = s0_hs_q;
  assign stage_tag[0] = s0_tag_q;
  assign stage_vld[0] = s0_vld_q;

  // ---------------- S1..S_LEVELS: one registered prefix level each ----------
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int SPAN = 1 << k;

    gp_t  [WIDTH:0]   gp_d;
    gp_t  [WIDTH:0]   gp_q;
    logic [WIDTH-1:0] hs_q;
    logic [TAG_W-1:0] tag_q;
    logic             vld_q;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
      if (i >= SPAN) begin : g_cell
        prefix_cell u_cell (
          .hi_i  (stage_gp[k][i]),
          .lo_i  (stage_gp[k][i-SPAN]),
          .res_o (gp_d[i])
        );
      end else begin : g_pass
        assign gp_d[i] = stage_gp[k][i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        gp_q  <= '0;
        hs_q  <= '0;
        tag_q <= '0;
      end else if (en) begin
        vld_q <= stage_vld[k];
        gp_q  <= gp_d;
        hs_q  <= stage_hs[k];
        tag_q <= stage_tag[k];
      end
    end

    assign stage_gp[k+1]  = gp_q;
    assign stage_hs[k+1]  = hs_q;
    assign stage_tag[k+1] = tag_q;
    assign stage_vld[k+1] = vld_q;
  end

  // ---------------- S_LEVELS+1: sum and flags --------------------------------
  gp_t [WIDTH:0] gf;
  gp_t           top_gp;

  assign gf = stage_gp[LEVELS];

  // After LEVELS levels each entry spans WINDOW positions. When WIDTH is a
  // power of two the top entry spans bits 0..WIDTH-1 but stops just short of
  // the carry-in at entry 0, so one more combine folds it in for cout.
  if (WINDOW == WIDTH) begin : g_top_fold
    prefix_cell u_top (
      .hi_i  (gf[WIDTH]),
      .lo_i  (gf[0]),
      .res_o (top_gp)
    );
  end else begin : g_top_direct
    assign top_gp = gf[WIDTH];
  end

  logic             unused_gp;
  assign unused_gp = ^{top_gp.p, gf};

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  // gf[i].g is the carry into bit i.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i] = stage_hs[LEVELS][i] ^ gf[i].g;
    end
    cout_d = top_gp.g;
    ovf_d  = top_gp.g ^ gf[WIDTH-1].g;
    zero_d = ~|sum_d;
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      tag_out_q   <= '0;
    end else if (en) begin
      out_valid_q <= stage_vld[LEVELS];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      tag_out_q   <= stage_tag[LEVELS];
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Self-checking bench: three instances (WIDTH 32, 8, 12) share operand drivers;
// `sel` picks which one receives in_valid and a random out_ready, the others
// sit idle with out_ready high. Expected results come from integer arithmetic.
module tb_prefix_addsub_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [3:0]  tag;
  } op_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          sel;
  logic        drv_vld, drv_rdy, drv_sub, drv_cin;
  logic [31:0] drv_a, drv_b;
  logic [3:0]  drv_tag;

  int n_checks = 0;
  int n_fail   = 0;

  op_t  op_q[$];
  op_t  acc_q[$];
  res_t obs_q[$];

  // ---- per-instance wiring ----
  logic vld32, vld8, vld12, ordy32, ordy8, ordy12;
  logic irdy32, irdy8, irdy12, ov32, ov8, ov12;
  logic co32, co8, co12, of32, of8, of12, z32, z8, z12;
  logic [31:0] sum32;
  logic [7:0]  sum8;
  logic [11:0] sum12;
  logic [3:0]  t32, t8, t12;

  assign vld32  = drv_vld && (sel == 0);
  assign vld8   = drv_vld && (sel == 1);
  assign vld12  = drv_vld && (sel == 2);
  assign ordy32 = (sel == 0) ? drv_rdy : 1'b1;
  assign ordy8  = (sel == 1) ? drv_rdy : 1'b1;
  assign ordy12 = (sel == 2) ? drv_rdy : 1'b1;

  prefix_addsub_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld32), .in_ready(irdy32),
    .a(drv_a), .b(drv_b), .sub(drv_sub), .cin(drv_cin), .tag_in(drv_tag),
    .out_valid(ov32), .out_ready(ordy32), .sum(sum32), .cout(co32),
    .ovf(of32), .zero(z32), .tag_out(t32));

  prefix_addsub_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(irdy8),
    .a(drv_a[7:0]), .b(drv_b[7:0]), .sub(drv_sub), .cin(drv_cin), .tag_in(drv_tag),
    .out_valid(ov8), .out_ready(ordy8), .sum(sum8), .cout(co8),
    .ovf(of8), .zero(z8), .tag_out(t8));

  prefix_addsub_pipe #(.WIDTH(12), .TAG_W(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld12), .in_ready(irdy12),
    .a(drv_a[11:0]), .b(drv_b[11:0]), .sub(drv_sub), .cin(drv_cin), .tag_in(drv_tag),
    .out_valid(ov12), .out_ready(ordy12), .sum(sum12), .cout(co12),
    .ovf(of12), .zero(z12), .tag_out(t12));

  // ---- observed view of the selected instance ----
  logic        o_vld, o_in_rdy, o_cout, o_ovf, o_zero;
  logic [31:0] o_sum;
  logic [3:0]  o_tag;

  always_comb begin
    o_vld = ov32; o_in_rdy = irdy32; o_sum = sum32;
    o_cout = co32; o_ovf = of32; o_zero = z32; o_tag = t32;
    if (sel == 1) begin
      o_vld = ov8; o_in_rdy = irdy8; o_sum = {24'b0, sum8};
      o_cout = co8; o_ovf = of8; o_zero = z8; o_tag = t8;
    end else if (sel == 2) begin
      o_vld = ov12; o_in_rdy = irdy12; o_sum = {20'b0, sum12};
      o_cout = co12; o_ovf = of12; o_zero = z12; o_tag = t12;
    end
  end

  // ---- reference model: plain integer arithmetic on w-bit operands ----
  function automatic res_t ref_res(input int w, input op_t op);
    longint m, ua, ub, c, full, sa, sb, sr;
    logic [63:0] wrapped;
    res_t r;
    m  = longint'(1) << w;
    ua = longint'(op.a) & (m - 1);
    ub = longint'(op.b) & (m - 1);
    c  = longint'(op.cin);
    if (!op.sub) begin
      full   = ua + ub + c;
      r.cout = (full >= m);
    end else begin
      full   = ua - ub - c;
      r.cout = (full >= 0);
    end
    wrapped = 64'(full & (m - 1));
    r.sum   = wrapped[31:0];
    r.zero  = (wrapped == 64'd0);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = op.sub ? (sa - sb - c) : (sa + sb + c);
    r.ovf = (sr < -(m / 2)) || (sr >= m / 2);
    r.tag = op.tag;
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.a   = $urandom;
    op.b   = $urandom;
    op.sub = 1'($urandom_range(1));
    op.cin = 1'($urandom_range(1));
    op.tag = 4'($urandom_range(15));
    return op;
  endfunction

  function automatic res_t observed();
    res_t r;
    r = '{sum: o_sum, cout: o_cout, ovf: o_ovf, zero: o_zero, tag: o_tag};
    return r;
  endfunction

  // ---- drivers (called at posedge+1, return at posedge+1) ----
  task automatic send_one(input op_t op, output res_t r, output int lat);
    {drv_a, drv_b, drv_sub, drv_cin, drv_tag} = op;
    drv_vld = 1'b1;
    drv_rdy = 1'b1;
    @(posedge clk); #1;
    drv_vld = 1'b0;
    lat = 1;
    while (!o_vld && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = observed();
    if (!o_vld) lat = -1;
  endtask

  task automatic run_stream(input int vld_pct, input int rdy_pct,
                            output bit timeout, output int rdy_bad, output int extra);
    int  sent, cyc, n, budget;
    bit  pend;
    op_t cur;
    sent = 0; cyc = 0; pend = 0; rdy_bad = 0; extra = 0;
    n = op_q.size();
    budget = n * 20 + 200;
    cur = '0;
    acc_q.delete();
    obs_q.delete();
    while ((sent < n || obs_q.size() < n) && cyc < budget) begin
      if (!pend && sent < n && $urandom_range(99) < vld_pct) begin
        cur  = op_q[sent];
        pend = 1'b1;
      end
      {drv_a, drv_b, drv_sub, drv_cin, drv_tag} = cur;
      drv_vld = pend;
      drv_rdy = ($urandom_range(99) < rdy_pct);
      #1;
      if (o_in_rdy !== (!o_vld || drv_rdy)) rdy_bad++;
      if (o_vld && drv_rdy) obs_q.push_back(observed());
      if (pend && o_in_rdy) begin
        acc_q.push_back(cur);
        sent++;
        pend = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    timeout = (cyc >= budget);
    drv_vld = 1'b0;
    drv_rdy = 1'b1;
    repeat (10) begin
      if (o_vld) extra++;
      @(posedge clk); #1;
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    #12;
    n_checks++; if (ov32 !== 1'b0 || ov8 !== 1'b0 || ov12 !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b%b%b required 000", ov32, ov8, ov12); end
    n_checks++; if (irdy32 !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", irdy32); end
    n_checks++; if (sum32 !== 32'h0) begin n_fail++;
      $display("FAIL reset_sum: got %h required 0", sum32); end
    n_checks++; if ({co32, of32, z32} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags: got cout/ovf/zero=%b required 000", {co32, of32, z32}); end
    n_checks++; if (t32 !== 4'h0) begin n_fail++;
      $display("FAIL reset_tag: got %h required 0", t32); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (irdy32 !== 1'b1 || ov32 !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_handshake: got in_ready=%b out_valid=%b required 1/0", irdy32, ov32); end
  endtask

  task automatic test_directed32();
    logic [31:0] da [8], db [8], es [8];
    logic        ds [8], dc [8], ec [8], eo [8];
    op_t  op;
    res_t r, e;
    int   lat;
    da = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd10, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'h1234};
    db = '{32'd1,        32'd1,        32'd7, 32'd3,  32'd0, 32'd1,        32'd0,        32'h1234};
    ds = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    es = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'd6, 32'd1, 32'h7FFFFFFF, 32'h0, 32'h0};
    ec = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    eo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      op = '{a: da[i], b: db[i], sub: ds[i], cin: dc[i], tag: 4'(i + 3)};
      send_one(op, r, lat);
      e = '{sum: es[i], cout: ec[i], ovf: eo[i], zero: (es[i] == 32'h0), tag: 4'(i + 3)};
      n_checks++; if (lat !== 7) begin n_fail++;
        $display("FAIL directed32[%0d] latency: got %0d required 7", i, lat); end
      n_checks++; if (r !== e) begin n_fail++;
        $display("FAIL directed32[%0d] result: got sum=%h c=%b v=%b z=%b t=%h required sum=%h c=%b v=%b z=%b t=%h",
                 i, r.sum, r.cout, r.ovf, r.zero, r.tag, e.sum, e.cout, e.ovf, e.zero, e.tag); end
    end
  endtask

  task automatic test_latency(input int s, input int w, input int exp_lat);
    op_t  op;
    res_t r, e;
    int   lat;
    sel = s;
    op = rand_op();
    send_one(op, r, lat);
    e = ref_res(w, op);
    n_checks++; if (lat !== exp_lat) begin n_fail++;
      $display("FAIL latency_w%0d: got %0d required %0d", w, lat, exp_lat); end
    n_checks++; if (r !== e) begin n_fail++;
      $display("FAIL single_w%0d result: got %h required %h", w, r, e); end
  endtask

  task automatic test_stream32();
    bit to; int bad, extra;
    sel = 0;
    op_q.delete();
    for (int i = 0; i < 200; i++) op_q.push_back(rand_op());
    run_stream(70, 70, to, bad, extra);
    n_checks++; if (to !== 1'b0) begin n_fail++;
      $display("FAIL stream32 timeout: got %0d results required 200", obs_q.size()); end
    n_checks++; if (bad !== 0) begin n_fail++;
      $display("FAIL stream32 in_ready: got %0d bad cycles required 0", bad); end
    n_checks++; if (obs_q.size() !== 200 || extra !== 0) begin n_fail++;
      $display("FAIL stream32 count: got %0d+%0d extra required 200+0", obs_q.size(), extra); end
    for (int i = 0; i < obs_q.size() && i < 200; i++) begin
      n_checks++; if (obs_q[i] !== ref_res(32, op_q[i])) begin n_fail++;
        $display("FAIL stream32[%0d]: got %h required %h", i, obs_q[i], ref_res(32, op_q[i])); end
    end
  endtask

  task automatic test_reset_midflight();
    op_t  op;
    res_t r;
    int   lat, seen;
    sel = 0;
    drv_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {drv_a, drv_b, drv_sub, drv_cin, drv_tag} = rand_op();
      drv_vld = 1'b1;
      @(posedge clk); #1;
    end
    drv_vld = 1'b0;
    n_checks++; if (ov32 !== 1'b1) begin n_fail++;
      $display("FAIL midflight_pre_vld: got %b required 1", ov32); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov32 !== 1'b0 || irdy32 !== 1'b1 || sum32 !== 32'h0) begin n_fail++;
      $display("FAIL midflight_reset: got vld=%b rdy=%b sum=%h required 0/1/0", ov32, irdy32, sum32); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    repeat (12) begin
      if (ov32) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 0) begin n_fail++;
      $display("FAIL midflight_stale: got %0d valid cycles required 0", seen); end
    op = rand_op();
    send_one(op, r, lat);
    n_checks++; if (lat !== 7) begin n_fail++;
      $display("FAIL midflight_latency: got %0d required 7", lat); end
    n_checks++; if (r !== ref_res(32, op)) begin n_fail++;
      $display("FAIL midflight_result: got %h required %h", r, ref_res(32, op)); end
  endtask

  task automatic test_sweep8();
    logic [7:0] bv [16];
    bit to; int bad, extra, n;
    bv = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h55, 8'h7E, 8'h7F, 8'h80,
           8'h81, 8'hAA, 8'hF0, 8'hFE, 8'hFF, 8'h3C, 8'hC3, 8'h40};
    sel = 1;
    op_q.delete();
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < 16; j++)
        for (int m = 0; m < 4; m++)
          op_q.push_back('{a: 32'(a), b: {24'b0, bv[j]}, sub: m[1], cin: m[0], tag: 4'(a + j)});
    n = op_q.size();
    run_stream(100, 100, to, bad, extra);
    n_checks++; if (to !== 1'b0 || obs_q.size() !== n || extra !== 0) begin n_fail++;
      $display("FAIL sweep8 count: got %0d+%0d required %0d+0", obs_q.size(), extra, n); end
    for (int i = 0; i < obs_q.size() && i < n; i++) begin
      n_checks++; if (obs_q[i] !== ref_res(8, op_q[i])) begin n_fail++;
        $display("FAIL sweep8[%0d]: got %h required %h", i, obs_q[i], ref_res(8, op_q[i])); end
    end
  endtask

  task automatic test_random12();
    bit to; int bad, extra;
    sel = 2;
    op_q.delete();
    for (int i = 0; i < 1000; i++) op_q.push_back(rand_op());
    run_stream(80, 75, to, bad, extra);
    n_checks++; if (bad !== 0) begin n_fail++;
      $display("FAIL random12 in_ready: got %0d bad cycles required 0", bad); end
    n_checks++; if (to !== 1'b0 || obs_q.size() !== 1000 || extra !== 0) begin n_fail++;
      $display("FAIL random12 count: got %0d+%0d required 1000+0", obs_q.size(), extra); end
    for (int i = 0; i < obs_q.size() && i < 1000; i++) begin
      n_checks++; if (obs_q[i] !== ref_res(12, op_q[i])) begin n_fail++;
        $display("FAIL random12[%0d]: got %h required %h", i, obs_q[i], ref_res(12, op_q[i])); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 0;
    drv_vld = 1'b0;
    drv_rdy = 1'b1;
    drv_a   = '0;
    drv_b   = '0;
    drv_sub = 1'b0;
    drv_cin = 1'b0;
    drv_tag = '0;
    test_reset();
    test_directed32();
    test_latency(0, 32, 7);
    test_latency(1, 8, 5);
    test_latency(2, 12, 6);
    test_stream32();
    test_reset_midflight();
    test_sweep8();
    test_random12();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
